// File: rtl/port_read_flush_tracker_pkg.sv
// Shared port-gasket definitions for the read flush tracker.
// Holds the flush FSM encoding and the default sizing limits.
// Pure declarations: no logic, so no latency or backpressure of its own.
package port_read_flush_tracker_pkg;

    localparam int DEF_MAX_OUTSTANDING = 256;
    localparam int DEF_FLUSH_TIMEOUT   = 4096;

    typedef enum int unsigned {
        RUN_B     = 0,
        DRAIN_B   = 1,
        DONE_B    = 2,
        TIMEOUT_B = 3
    } state_bit_e;

    // One-hot state vector; each state sets only the bit named by state_bit_e.
    typedef enum logic [3:0] {
        ST_RUN     = 4'(1 << RUN_B),
        ST_DRAIN   = 4'(1 << DRAIN_B),
        ST_DONE    = 4'(1 << DONE_B),
        ST_TIMEOUT = 4'(1 << TIMEOUT_B)
    } state_e;

endpackage

// File: rtl/port_outstanding_cnt.sv
// Outstanding-read counter: +1 on inc, -1 on dec, net zero when both, clear on force_clr.
// Count and underflow flag are registered, so both update one cycle after the event.
// No backpressure of its own; it saturates at MAX and never goes below zero.
module port_outstanding_cnt #(
    parameter int MAX = 256,
    parameter int CW  = $clog2(MAX) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    input  logic          force_clr,
    output logic [CW-1:0] cnt,
    output logic          underflow
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            underflow <= 1'b0;
        end else begin
            // A completion with nothing outstanding is only an error if no read fired alongside it.
            underflow <= dec & ~inc & (cnt == '0);
            if (force_clr) begin
                cnt <= '0;
            end else if (inc & ~dec) begin
                if (cnt != CW'(MAX)) cnt <= cnt + CW'(1);
            end else if (dec & ~inc) begin
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/port_read_flush_tracker.sv
// Tracks AFU reads in flight and drains them before a port soft reset completes.
// Gating is combinational; done and error flags are registered (done 1 cycle after cnt hits 0).
// Backpressure: reads are blocked outside RUN and whenever MAX_OUTSTANDING reads are in flight.
module port_read_flush_tracker
    import port_read_flush_tracker_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int FLUSH_TIMEOUT   = DEF_FLUSH_TIMEOUT
) (
    input  logic                               clk_2x,
    input  logic                               rst_2x,
    input  logic                               i_afu_softreset,
    input  logic                               i_afu_rd_valid,
    output logic                               o_afu_rd_ready,
    output logic                               o_fab_rd_valid,
    input  logic                               i_fab_rd_ready,
    input  logic                               i_cpl_valid,
    input  logic                               i_cpl_last,
    output logic                               o_read_flush_done,
    output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding_cnt,
    output logic                               o_flush_timeout_err,
    output logic                               o_cpl_underflow_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int TW = $clog2(FLUSH_TIMEOUT) + 1;

    state_e        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] cnt;
    logic          block;
    logic          full;
    logic          fire;
    logic          cpl;

    assign block          = (state != ST_RUN);
    assign full           = (cnt == CW'(MAX_OUTSTANDING));
    assign o_fab_rd_valid = i_afu_rd_valid & ~block & ~full;
    assign o_afu_rd_ready = i_fab_rd_ready & ~block & ~full;
    assign fire           = i_afu_rd_valid & o_afu_rd_ready;
    assign cpl            = i_cpl_valid & i_cpl_last;

    port_outstanding_cnt #(
        .MAX (MAX_OUTSTANDING),
        .CW  (CW)
    ) u_cnt (
        .clk       (clk_2x),
        .rst       (rst_2x),
        .inc       (fire),
        .dec       (cpl),
        .force_clr (state[TIMEOUT_B]),
        .cnt       (cnt),
        .underflow (o_cpl_underflow_err)
    );

    assign o_outstanding_cnt = cnt;

    // Done and timeout flags are written alongside the state so they line up with it.
    always_ff @(posedge clk_2x) begin
        if (rst_2x) begin
            state               <= ST_DONE;
            timer               <= '0;
            o_read_flush_done   <= 1'b1;
            o_flush_timeout_err <= 1'b0;
        end else begin
            o_flush_timeout_err <= 1'b0;
            case (state)
                ST_RUN: begin
                    timer <= '0;
                    if (i_afu_softreset) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    timer <= timer + TW'(1);
                    if (cnt == '0) begin
                        state             <= ST_DONE;
                        o_read_flush_done <= 1'b1;
                    end else if (timer == TW'(FLUSH_TIMEOUT - 1)) begin
                        state               <= ST_TIMEOUT;
                        o_flush_timeout_err <= 1'b1;
                    end
                end
                ST_TIMEOUT: begin
                    state             <= ST_DONE;
                    o_read_flush_done <= 1'b1;
                end
                ST_DONE: begin
                    if (!i_afu_softreset) begin
                        state             <= ST_RUN;
                        o_read_flush_done <= 1'b0;
                    end
                end
                default: begin
                    state             <= ST_DONE;
                    o_read_flush_done <= 1'b1;
                end
            endcase
        end
    end

endmodule
